program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: Program_counter

Interface
REQ-001 Parameter WIDTH, default 32: bit width of the address input and of both address outputs.
REQ-002 Parameter RESET_ADDR, default 0: value loaded into the PC register on reset.
REQ-003 Parameter INCR, default 1: constant added to the current PC to form the next-sequential output; word-addressed, so not 4.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port Address, input, WIDTH bits: next-PC value supplied by upstream next-PC logic.
REQ-007 Port Out_Addr1, output, WIDTH bits: current PC, driven directly from the PC register.
REQ-008 Port Out_Addr2_plus_1, output, WIDTH bits: current PC + INCR.

Function
REQ-009 The block SHALL hold one WIDTH-bit PC register.
REQ-010 On every rising clk edge with rst low, the PC register SHALL load Address unconditionally; there is no enable or stall input.
REQ-011 Out_Addr1 SHALL equal the PC register, with one-cycle latency from Address.
REQ-012 Out_Addr2_plus_1 SHALL equal (PC + INCR) mod 2^WIDTH, derived only from the PC register with no combinational path from Address.
REQ-013 Out_Addr2_plus_1 SHALL be registered alongside the PC so it changes on the same edge as Out_Addr1.
REQ-014 Wrap-around: PC = 2^WIDTH-1 with INCR=1 SHALL give Out_Addr2_plus_1 = 0, with no error indication unless REQ-020 applies.
REQ-015 Changes on Address between clock edges SHALL NOT affect either output until the next rising edge.
REQ-016 An X/Z on Address SHALL propagate to the outputs only after a clock edge; no special handling.

Reset
REQ-017 While rst is high, Out_Addr1 SHALL be RESET_ADDR and Out_Addr2_plus_1 SHALL be RESET_ADDR+INCR, taking effect immediately without waiting for clk.
REQ-018 A rising clk edge while rst is high SHALL be ignored; rst dominates a simultaneous edge.
REQ-019 On the first rising edge after rst falls, the PC register SHALL load Address; reset asserted mid-run SHALL discard the current PC.

Configuration
REQ-020 Macro PC_WRAP_FLAG_EN:
- Defined: adds output pc_wrap (1 bit), registered; set high for exactly the cycle in which PC + INCR overflows WIDTH bits, otherwise low.
- pc_wrap SHALL be 0 during and after reset until an overflow occurs.
- Undefined: port and logic are absent, and all other behaviour is identical.

Verification
REQ-021 Reset check: assert rst with clk stopped -> Out_Addr1=0x00000000 and Out_Addr2_plus_1=0x00000001 immediately.
REQ-022 Load check: release rst, Address=0x00000010, one edge -> Out_Addr1=0x00000010, Out_Addr2_plus_1=0x00000011; no change before the edge.
REQ-023 Sequential run: Address driven 0,1,2,3 on successive edges -> Out_Addr1 trails Address by one cycle and Out_Addr2_plus_1 is always Out_Addr1+1.
REQ-024 Wrap check: Address=0xFFFFFFFF, one edge -> Out_Addr1=0xFFFFFFFF, Out_Addr2_plus_1=0x00000000; pc_wrap=1 only when PC_WRAP_FLAG_EN is defined.
REQ-025 Mid-run reset: after loading 0x00000100, pulse rst between edges -> outputs return to 0x00000000/0x00000001 asynchronously, and the next edge after release loads the current Address.
REQ-026 Glitch check: toggle Address between edges -> outputs remain stable until the next rising edge.

Source files
------------

// File: rtl/program_counter.sv
// Program counter: one WIDTH-bit PC register loaded from Address every
// rising clk edge, plus a registered PC+INCR (next-sequential) output.
//
// Parameters:
//   WIDTH      - address width
//   RESET_ADDR - PC value held while rst is high
//   INCR       - next-sequential step (word addressed, default 1)
//
// Ports:
//   clk              - clock, rising edge
//   rst              - asynchronous active-high reset
//   Address          - next-PC value from upstream next-PC logic
//   Out_Addr1        - current PC
//   Out_Addr2_plus_1 - current PC + INCR (mod 2^WIDTH)
//   pc_wrap          - only with PC_WRAP_FLAG_EN defined: high for the
//                      cycle in which PC + INCR overflowed WIDTH bits
//
// Build option: define PC_WRAP_FLAG_EN to add the pc_wrap output.

module program_counter #(
    parameter int unsigned          WIDTH      = 32,
    parameter logic [WIDTH-1:0]     RESET_ADDR = '0,
    parameter logic [WIDTH-1:0]     INCR       = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Address,
    output logic [WIDTH-1:0] Out_Addr1,
`ifdef PC_WRAP_FLAG_EN
    output logic             pc_wrap,
`endif
    output logic [WIDTH-1:0] Out_Addr2_plus_1
);

    localparam logic [WIDTH-1:0] LP_RST_INC = RESET_ADDR + INCR;

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pc_inc;
    logic [WIDTH-1:0] w_pc_inc;

    // The incremented value is precomputed from Address and captured on
    // the same edge as the PC, so both outputs come straight from flops
    // and change together; nothing combinational reaches the outputs.
`ifdef PC_WRAP_FLAG_EN
    logic [WIDTH:0] w_sum;
    logic           r_wrap;

    assign w_sum    = {1'b0, Address} + {1'b0, INCR};
    assign w_pc_inc = w_sum[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_sum[WIDTH];
        end
    end

    assign pc_wrap = r_wrap;
`else
    assign w_pc_inc = Address + INCR;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_ADDR;
            r_pc_inc <= LP_RST_INC;
        end else begin
            r_pc     <= Address;
            r_pc_inc <= w_pc_inc;
        end
    end

    assign Out_Addr1        = r_pc;
    assign Out_Addr2_plus_1 = r_pc_inc;

endmodule

// File: tb/tb_program_counter.sv
// Directed testbench for program_counter (default parameters).
// Hand-computed expectations for reset, load, sequence, wrap and glitches.

module tb_program_counter;

    logic        clk;
    logic        rst;
    logic [31:0] Address;
    logic [31:0] Out_Addr1;
    logic [31:0] Out_Addr2_plus_1;
`ifdef PC_WRAP_FLAG_EN
    logic        pc_wrap;
`endif

    int n_tests;
    int n_fail;

    program_counter #(
        .WIDTH      (32),
        .RESET_ADDR (32'h0),
        .INCR       (32'h1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .Address          (Address),
        .Out_Addr1        (Out_Addr1),
`ifdef PC_WRAP_FLAG_EN
        .pc_wrap          (pc_wrap),
`endif
        .Out_Addr2_plus_1 (Out_Addr2_plus_1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_pc(input string tag, input logic [31:0] a1,
                            input logic [31:0] a2);
        check({tag, ".a1"}, Out_Addr1, a1);
        check({tag, ".a2"}, Out_Addr2_plus_1, a2);
    endtask

    // one full clock period; returns 1 time unit after the rising edge
    task automatic edge_clk();
        #4 clk = 1'b0;
        #5 clk = 1'b1;
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clk     = 1'b0;
        rst     = 1'b1;
        Address = 32'h55;

        // reset with clock stopped
        #1;
        check_pc("rst", 32'h0, 32'h1);
`ifdef PC_WRAP_FLAG_EN
        check("rst.wrap", {31'd0, pc_wrap}, 32'h0);
`endif

        // edge while reset held is ignored
        edge_clk();
        check_pc("rst_edge", 32'h0, 32'h1);

        // load 0x10, no change before the edge
        rst     = 1'b0;
        Address = 32'h10;
        #1;
        check_pc("pre_load", 32'h0, 32'h1);
        edge_clk();
        check_pc("load", 32'h10, 32'h11);

        // sequential run 0..3
        for (int i = 0; i < 4; i++) begin
            Address = 32'(i);
            #1;
            check_pc("seq_pre", (i == 0) ? 32'h10 : 32'(i - 1),
                     (i == 0) ? 32'h11 : 32'(i));
            edge_clk();
            check_pc("seq", 32'(i), 32'(i + 1));
        end

        // wrap-around
        Address = 32'hFFFF_FFFF;
        edge_clk();
        check_pc("wrap", 32'hFFFF_FFFF, 32'h0);
`ifdef PC_WRAP_FLAG_EN
        check("wrap.flag", {31'd0, pc_wrap}, 32'h1);
`endif
        Address = 32'h5;
        edge_clk();
        check_pc("post_wrap", 32'h5, 32'h6);
`ifdef PC_WRAP_FLAG_EN
        check("post_wrap.flag", {31'd0, pc_wrap}, 32'h0);
`endif

        // mid-run asynchronous reset
        Address = 32'h100;
        edge_clk();
        check_pc("ld100", 32'h100, 32'h101);
        #1 rst = 1'b1;
        #1;
        check_pc("mid_rst", 32'h0, 32'h1);
        rst     = 1'b0;
        Address = 32'h200;
        #1;
        check_pc("mid_rel", 32'h0, 32'h1);
        edge_clk();
        check_pc("after_rst", 32'h200, 32'h201);

        // glitching Address between edges
        Address = 32'h300;
        #1 Address = 32'hABC;
        #1;
        check_pc("glitch", 32'h200, 32'h201);
        Address = 32'h301;
        edge_clk();
        check_pc("glitch_ld", 32'h301, 32'h302);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
